// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared constants, types and helpers for the fetch stage.
//               - c_RESET_PC      default first fetch address
//               - c_INSTR_ALIGN   required low two bits of a fetch target
//               - c_INSTR_WIDTH   instruction word width
//               - fault_cause_e   fault-cause encoding kept for a trap unit
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    localparam int unsigned c_RESET_PC    = 0;
    localparam logic [1:0]  c_INSTR_ALIGN = 2'b00;
    localparam int          c_INSTR_WIDTH = 32;

    // Not consumed inside the fetch stage yet; a trap unit will decode it.
    typedef enum logic [1:0] {
        FAULT_NONE       = 2'd0,
        FAULT_MISALIGNED = 2'd1,
        FAULT_RANGE      = 2'd2
    } fault_cause_e;

    function automatic logic is_aligned(input logic [1:0] low_bits);
        return low_bits == c_INSTR_ALIGN;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Fetch-to-decode valid/ready handshake.
//               instr_valid  fetch -> decode   entry present
//               instr_ready  decode -> fetch   entry accepted this cycle
//               instr        fetch -> decode   instruction word
//               instr_pc     fetch -> decode   PC of instr
//               master = fetch side, slave = decode side.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int OPD_WIDTH = 32
);
    logic                     instr_valid;
    logic                     instr_ready;
    logic [c_INSTR_WIDTH-1:0] instr;
    logic [OPD_WIDTH-1:0]     instr_pc;

    modport master (output instr_valid, output instr, output instr_pc,
                    input  instr_ready);
    modport slave  (input  instr_valid, input  instr, input  instr_pc,
                    output instr_ready);
endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous circular-buffer FIFO with flush.
//               clk, rst     clock, asynchronous active-high reset
//               flush        empty the buffer (wins over push)
//               push/wr_data write an entry
//               pop          consume the head (ignored when empty)
//               rd_data      head entry; holds last presented value when empty
//               valid        buffer not empty
//               count        number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             flush,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] wr_data,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] rd_data,
    output logic                  valid,
    output logic      [CW-1:0]    count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_hold;
    logic [WIDTH-1:0] w_head;
    logic             w_do_pop;
    logic             w_do_push;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_do_pop  = pop & (r_count != '0) & ~flush;
    assign w_do_push = push & ~flush;

    // When empty, re-present whatever was last on the output.
    assign w_head  = (r_count != '0) ? r_mem[r_rd_ptr] : r_hold;
    assign rd_data = w_head;
    assign valid   = (r_count != '0);
    assign count   = r_count;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_hold   <= '0;
        end else begin
            r_hold <= w_head;
            if (flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
                if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
                r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
            end
        end
    end

    // The producer throttles itself on occupancy, so a push into a full
    // buffer without a simultaneous pop must never happen.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_do_push && !w_do_pop && r_count == CW'(DEPTH)));

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage in front of program_memory. Owns the
//               PC, tracks the single in-flight fetch, buffers responses in a
//               small FIFO and presents them to decode via valid/ready.
//               clk, rst       clock, asynchronous active-high reset
//               mem_addr       byte address to program_memory (from pc reg)
//               mem_data       registered instruction word from memory
//               mem_pc         registered address echo from memory
//               redirect_en    taken branch/jump; flushes the pipeline
//               redirect_pc    new fetch target
//               dec            decode handshake (instr_valid/ready/instr/pc)
//               fetch_fault    sticky illegal-redirect flag
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          OPD_WIDTH  = 32,
    parameter int          PC_WIDTH   = 12,
    parameter int unsigned RESET_PC   = c_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    output logic      [PC_WIDTH-1:0]      mem_addr,
    input  wire logic [c_INSTR_WIDTH-1:0] mem_data,
    input  wire logic [OPD_WIDTH-1:0]     mem_pc,
    input  wire logic                     redirect_en,
    input  wire logic [OPD_WIDTH-1:0]     redirect_pc,
    fetch_unit_if.master                  dec,
    output logic                          fetch_fault
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = c_INSTR_WIDTH + OPD_WIDTH;

    logic [PC_WIDTH-1:0] r_pc;
    logic                r_inflight;
    logic                r_fault;

    logic [CW-1:0]       w_count;
    logic [CW:0]         w_occ;
    logic                w_pop;
    logic                w_push;
    logic                w_issue;
    logic                w_flush;
    logic                w_bad_target;
    logic                w_hi_nonzero;
    logic [EW-1:0]       w_rd_data;

    generate
        if (OPD_WIDTH > PC_WIDTH) begin : g_hi_chk
            assign w_hi_nonzero = |redirect_pc[OPD_WIDTH-1:PC_WIDTH];
        end else begin : g_no_hi_chk
            assign w_hi_nonzero = 1'b0;
        end
    endgenerate

    // Once faulted, redirects are ignored entirely.
    assign w_flush      = redirect_en & ~r_fault;
    assign w_bad_target = w_flush & (~is_aligned(redirect_pc[1:0]) | w_hi_nonzero);

    assign w_pop  = dec.instr_valid & dec.instr_ready;
    assign w_push = r_inflight & ~w_flush;

    // Reserve a slot for the outstanding response so the FIFO can't overflow;
    // a same-cycle pop frees a slot, which keeps one-per-cycle throughput.
    assign w_occ   = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign w_issue = ~redirect_en & ~r_fault &
                     ((w_occ - {{CW{1'b0}}, w_pop}) < (CW+1)'(FIFO_DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= PC_WIDTH'(RESET_PC);
            r_inflight <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_bad_target) begin
                r_fault <= 1'b1;
            end
            if (w_flush && !w_bad_target) begin
                r_pc <= redirect_pc[PC_WIDTH-1:0];
            end else if (w_issue) begin
                r_pc <= r_pc + PC_WIDTH'(4);
            end
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (w_flush),
        .push    (w_push),
        .wr_data ({mem_data, mem_pc}),
        .pop     (w_pop),
        .rd_data (w_rd_data),
        .valid   (dec.instr_valid),
        .count   (w_count)
    );

    assign dec.instr    = w_rd_data[EW-1:OPD_WIDTH];
    assign dec.instr_pc = w_rd_data[OPD_WIDTH-1:0];
    assign mem_addr     = r_pc;
    assign fetch_fault  = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit with a registered
//               program_memory model (data/pc returned one edge after addr).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] mem_addr;
    logic [31:0] mem_data = '0;
    logic [31:0] mem_pc   = '0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fetch_fault;

    int n_pass  = 0;
    int n_total = 0;

    fetch_unit_if #(.OPD_WIDTH(32)) dec_if ();

    fetch_unit #(
        .OPD_WIDTH  (32),
        .PC_WIDTH   (12),
        .RESET_PC   (0),
        .FIFO_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_pc      (mem_pc),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .dec         (dec_if),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    // Program image: ADD x2,x3,x4 at 0, JALR at 104, else 0x1300_0000 | addr.
    function automatic logic [31:0] rom(input logic [11:0] a);
        if (a == 12'd0)   return 32'h0041_8133;
        if (a == 12'd104) return 32'h0000_80E7;
        return 32'h1300_0000 | {20'd0, a};
    endfunction

    always @(posedge clk) begin
        mem_data <= rom(mem_addr);
        mem_pc   <= {20'd0, mem_addr};
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        dec_if.instr_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (dec_if.instr_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", dec_if.instr_valid); else n_pass++;
        n_total++; if (dec_if.instr !== 32'd0) $display("FAIL reset_instr: got %h want 0", dec_if.instr); else n_pass++;
        n_total++; if (dec_if.instr_pc !== 32'd0) $display("FAIL reset_pc: got %h want 0", dec_if.instr_pc); else n_pass++;
        n_total++; if (fetch_fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", fetch_fault); else n_pass++;
        n_total++; if (mem_addr !== 12'd0) $display("FAIL reset_addr: got %0d want 0", mem_addr); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_stream;
        step;
        n_total++; if (dec_if.instr_valid !== 1'b0) $display("FAIL stream_edge1_valid: got %b want 0", dec_if.instr_valid); else n_pass++;
        n_total++; if (mem_addr !== 12'd4) $display("FAIL stream_edge1_addr: got %0d want 4", mem_addr); else n_pass++;
        step;
        n_total++; if (dec_if.instr_valid !== 1'b1) $display("FAIL stream_first_valid: got %b want 1", dec_if.instr_valid); else n_pass++;
        n_total++; if (dec_if.instr !== 32'h0041_8133) $display("FAIL stream_first_instr: got %h want 00418133", dec_if.instr); else n_pass++;
        n_total++; if (dec_if.instr_pc !== 32'd0) $display("FAIL stream_first_pc: got %0d want 0", dec_if.instr_pc); else n_pass++;
        for (int i = 1; i <= 3; i++) begin
            step;
            n_total++; if (dec_if.instr_valid !== 1'b1 || dec_if.instr_pc !== 32'(4 * i))
                $display("FAIL stream_pc%0d: got v=%b pc=%0d want v=1 pc=%0d", i, dec_if.instr_valid, dec_if.instr_pc, 4 * i); else n_pass++;
            n_total++; if (dec_if.instr !== (32'h1300_0000 + 32'(4 * i)))
                $display("FAIL stream_instr%0d: got %h want %h", i, dec_if.instr, 32'h1300_0000 + 32'(4 * i)); else n_pass++;
        end
    endtask

    task automatic test_backpressure;
        dec_if.instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step;
            n_total++; if (dec_if.instr_valid !== 1'b1 || dec_if.instr_pc !== 32'd12)
                $display("FAIL bp_hold%0d: got v=%b pc=%0d want v=1 pc=12", i, dec_if.instr_valid, dec_if.instr_pc); else n_pass++;
            n_total++; if (mem_addr !== 12'd20) $display("FAIL bp_addr%0d: got %0d want 20", i, mem_addr); else n_pass++;
        end
        dec_if.instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step;
            n_total++; if (dec_if.instr_valid !== 1'b1 || dec_if.instr_pc !== 32'(16 + 4 * i))
                $display("FAIL bp_resume%0d: got v=%b pc=%0d want v=1 pc=%0d", i, dec_if.instr_valid, dec_if.instr_pc, 16 + 4 * i); else n_pass++;
        end
    endtask

    task automatic test_redirect;
        redirect_en = 1'b1;
        redirect_pc = 32'd104;
        step;
        redirect_en = 1'b0;
        n_total++; if (dec_if.instr_valid !== 1'b0) $display("FAIL redir_flush_valid: got %b want 0", dec_if.instr_valid); else n_pass++;
        n_total++; if (mem_addr !== 12'd104) $display("FAIL redir_addr: got %0d want 104", mem_addr); else n_pass++;
        step;
        n_total++; if (dec_if.instr_valid !== 1'b0) $display("FAIL redir_gap_valid: got %b want 0 (pc=%0d)", dec_if.instr_valid, dec_if.instr_pc); else n_pass++;
        step;
        n_total++; if (dec_if.instr_valid !== 1'b1 || dec_if.instr_pc !== 32'd104)
            $display("FAIL redir_target: got v=%b pc=%0d want v=1 pc=104", dec_if.instr_valid, dec_if.instr_pc); else n_pass++;
        n_total++; if (dec_if.instr !== 32'h0000_80E7) $display("FAIL redir_instr: got %h want 000080e7", dec_if.instr); else n_pass++;
        step;
        n_total++; if (dec_if.instr_valid !== 1'b1 || dec_if.instr_pc !== 32'd108)
            $display("FAIL redir_next: got v=%b pc=%0d want v=1 pc=108", dec_if.instr_valid, dec_if.instr_pc); else n_pass++;
    endtask

    task automatic test_fault;
        redirect_en = 1'b1;
        redirect_pc = 32'h66;
        step;
        redirect_en = 1'b0;
        n_total++; if (fetch_fault !== 1'b1) $display("FAIL fault_set: got %b want 1", fetch_fault); else n_pass++;
        n_total++; if (dec_if.instr_valid !== 1'b0) $display("FAIL fault_flush: got %b want 0", dec_if.instr_valid); else n_pass++;
        n_total++; if (mem_addr !== 12'd116) $display("FAIL fault_addr: got %0d want 116", mem_addr); else n_pass++;
        step;
        n_total++; if (dec_if.instr_valid !== 1'b0 || mem_addr !== 12'd116)
            $display("FAIL fault_frozen: got v=%b addr=%0d want v=0 addr=116", dec_if.instr_valid, mem_addr); else n_pass++;
        redirect_en = 1'b1;
        redirect_pc = 32'd0;
        step;
        redirect_en = 1'b0;
        n_total++; if (fetch_fault !== 1'b1 || mem_addr !== 12'd116)
            $display("FAIL fault_ignore_redir: got f=%b addr=%0d want f=1 addr=116", fetch_fault, mem_addr); else n_pass++;
        step;
        n_total++; if (dec_if.instr_valid !== 1'b0) $display("FAIL fault_still_idle: got %b want 0", dec_if.instr_valid); else n_pass++;
    endtask

    task automatic test_wrap;
        rst = 1'b1;
        #1;
        n_total++; if (fetch_fault !== 1'b0) $display("FAIL wrap_rst_fault: got %b want 0", fetch_fault); else n_pass++;
        step;
        rst = 1'b0;
        redirect_en = 1'b1;
        redirect_pc = 32'd4088;
        step;
        redirect_en = 1'b0;
        n_total++; if (mem_addr !== 12'd4088 || dec_if.instr_valid !== 1'b0)
            $display("FAIL wrap_redir: got addr=%0d v=%b want addr=4088 v=0", mem_addr, dec_if.instr_valid); else n_pass++;
        step;
        step;
        n_total++; if (dec_if.instr_pc !== 32'd4088 || dec_if.instr !== 32'h1300_0FF8)
            $display("FAIL wrap_4088: got pc=%0d instr=%h want pc=4088 instr=13000ff8", dec_if.instr_pc, dec_if.instr); else n_pass++;
        n_total++; if (mem_addr !== 12'd0) $display("FAIL wrap_addr: got %0d want 0", mem_addr); else n_pass++;
        step;
        n_total++; if (dec_if.instr_pc !== 32'd4092) $display("FAIL wrap_4092: got %0d want 4092", dec_if.instr_pc); else n_pass++;
        step;
        n_total++; if (dec_if.instr_valid !== 1'b1 || dec_if.instr_pc !== 32'd0 || dec_if.instr !== 32'h0041_8133)
            $display("FAIL wrap_zero: got v=%b pc=%0d instr=%h want v=1 pc=0 instr=00418133", dec_if.instr_valid, dec_if.instr_pc, dec_if.instr); else n_pass++;
        n_total++; if (fetch_fault !== 1'b0) $display("FAIL wrap_no_fault: got %b want 0", fetch_fault); else n_pass++;
    endtask

    task automatic test_async_reset;
        step;
        n_total++; if (dec_if.instr_valid !== 1'b1 || dec_if.instr_pc !== 32'd4)
            $display("FAIL arst_pre: got v=%b pc=%0d want v=1 pc=4", dec_if.instr_valid, dec_if.instr_pc); else n_pass++;
        #3;
        rst = 1'b1;
        #1;
        n_total++; if (dec_if.instr_valid !== 1'b0) $display("FAIL arst_valid: got %b want 0", dec_if.instr_valid); else n_pass++;
        n_total++; if (mem_addr !== 12'd0) $display("FAIL arst_addr: got %0d want 0", mem_addr); else n_pass++;
        n_total++; if (dec_if.instr_pc !== 32'd0) $display("FAIL arst_pc: got %0d want 0", dec_if.instr_pc); else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step;
        n_total++; if (dec_if.instr_valid !== 1'b0) $display("FAIL arst_edge1: got %b want 0", dec_if.instr_valid); else n_pass++;
        step;
        n_total++; if (dec_if.instr_valid !== 1'b1 || dec_if.instr_pc !== 32'd0)
            $display("FAIL arst_restart0: got v=%b pc=%0d want v=1 pc=0", dec_if.instr_valid, dec_if.instr_pc); else n_pass++;
        step;
        n_total++; if (dec_if.instr_pc !== 32'd4) $display("FAIL arst_restart4: got %0d want 4", dec_if.instr_pc); else n_pass++;
    endtask

    task automatic test_range_fault;
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_1000;
        step;
        redirect_en = 1'b0;
        n_total++; if (fetch_fault !== 1'b1 || dec_if.instr_valid !== 1'b0 || mem_addr !== 12'd12)
            $display("FAIL range_fault: got f=%b v=%b addr=%0d want f=1 v=0 addr=12", fetch_fault, dec_if.instr_valid, mem_addr); else n_pass++;
        #3;
        rst = 1'b1;
        #1;
        n_total++; if (fetch_fault !== 1'b0 || mem_addr !== 12'd0)
            $display("FAIL range_arst: got f=%b addr=%0d want f=0 addr=0", fetch_fault, mem_addr); else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        dec_if.instr_ready = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_fault();
        test_wrap();
        test_async_reset();
        test_range_fault();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
